srb_chain: RTL and testbench

- Parametrised shift-register bank: DEPTH stages, each WIDTH bits wide.
- Each stage selects between its shifted neighbour and a parallel shortcut input.
- Adds burst shifting, rotation, clear, and a done handshake, driven by a small control FSM.
- Sits between the BNN activation buffers and the XNOR/popcount datapath; feeds sliding-window operands.

---
 rtl/srb_chain.sv | 146 ++++++++++++++
 tb/tb_srb_chain.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/srb_chain.sv
// Shift-register bank feeding sliding-window operands to the XNOR/popcount datapath.
// A two-state FSM runs LOAD/CLEAR commands and SHIFT/ROTATE bursts, then pulses done.
module srb_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         shift_len,
    input  logic [WIDTH-1:0]         ser_in,
    input  logic [DEPTH*WIDTH-1:0]   par_in,
    output logic [DEPTH*WIDTH-1:0]   par_out,
    output logic [WIDTH-1:0]         ser_out,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Operation applied uniformly to every stage this cycle.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_SHIFT,
        OP_PAR,
        OP_ZERO
    } op_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] nbr     [DEPTH];
    op_e              op;
    mode_e            mode_in;

    assign mode_in = mode_e'(mode);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        op      = OP_HOLD;
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (mode_in)
                        MODE_LOAD: begin
                            op     = OP_PAR;
                            done_d = 1'b1;
                        end
                        MODE_CLEAR: begin
                            op     = OP_ZERO;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (shift_len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                mode_d  = mode_in;
                                cnt_d   = shift_len;
                                state_d = RUN;
                            end
                        end
                    endcase
                end
            end
            RUN: begin
                op    = OP_SHIFT;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Neighbour feeding each stage; stage 0 takes ser_in or wraps from the tail.
    always_comb begin
        nbr[0] = (mode_q == MODE_ROTATE) ? stage_q[DEPTH-1] : ser_in;
        for (int i = 1; i < DEPTH; i++) begin
            nbr[i] = stage_q[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            case (op)
                OP_SHIFT: stage_d[i] = nbr[i];
                OP_PAR:   stage_d[i] = par_in[i*WIDTH +: WIDTH];
                OP_ZERO:  stage_d[i] = '0;
                default:  stage_d[i] = stage_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_LOAD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            par_out[i*WIDTH +: WIDTH] = stage_q[i];
        end
    end

    assign ser_out = stage_q[DEPTH-1];
    assign busy    = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_srb_chain.sv
// Directed bench for srb_chain (WIDTH=1, DEPTH=4, CNT_W=4) with hand-computed expectations.
module tb_srb_chain;

    localparam int WIDTH = 1;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [1:0]             mode;
    logic [CNT_W-1:0]       shift_len;
    logic [WIDTH-1:0]       ser_in;
    logic [DEPTH*WIDTH-1:0] par_in;
    logic [DEPTH*WIDTH-1:0] par_out;
    logic [WIDTH-1:0]       ser_out;
    logic                   busy;
    logic                   done;

    int checks   = 0;
    int failures = 0;

    srb_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .shift_len (shift_len),
        .ser_in    (ser_in),
        .par_in    (par_in),
        .par_out   (par_out),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rot_exp [4];
    logic       rot_ser [4];

    initial begin
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        rot_ser = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; start = 1'b0; mode = 2'b00; shift_len = '0;
        ser_in = '0; par_in = '0;

        // Reset state
        tick();
        tick();
        check("rst_par_out", 32'(par_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b1;
        tick();

        // LOAD 1011
        mode = 2'b00; par_in = 4'b1011; start = 1'b1;
        tick();
        start = 1'b0; par_in = 4'b0000;
        check("load_par_out", 32'(par_out), 32'hB);
        check("load_done", 32'(done), 32'h1);
        check("load_busy", 32'(busy), 32'h0);
        tick();
        check("load_done_drop", 32'(done), 32'h0);

        // SHIFT len=2, ser_in 1 then 0
        mode = 2'b01; shift_len = 4'd2; ser_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("shift_start_busy", 32'(busy), 32'h1);
        check("shift_start_hold", 32'(par_out), 32'hB);
        check("shift_start_done", 32'(done), 32'h0);
        tick();
        check("shift1_par_out", 32'(par_out), 32'h7);
        check("shift1_busy", 32'(busy), 32'h1);
        ser_in = 1'b0;
        tick();
        check("shift2_par_out", 32'(par_out), 32'hE);
        check("shift2_busy", 32'(busy), 32'h0);
        check("shift2_done", 32'(done), 32'h1);
        tick();
        check("shift_done_drop", 32'(done), 32'h0);

        // LOAD 1000 then ROTATE len=4
        mode = 2'b00; par_in = 4'b1000; start = 1'b1;
        tick();
        check("load2_par_out", 32'(par_out), 32'h8);
        mode = 2'b10; shift_len = 4'd4; par_in = 4'b0000;
        tick();
        start = 1'b0;
        check("rot_start_busy", 32'(busy), 32'h1);
        check("rot_start_ser", 32'(ser_out), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rot%0d_par_out", i), 32'(par_out), 32'(rot_exp[i]));
            check($sformatf("rot%0d_ser_out", i), 32'(ser_out), 32'(rot_ser[i]));
            check($sformatf("rot%0d_done", i), 32'(done), (i == 3) ? 32'h1 : 32'h0);
            check($sformatf("rot%0d_busy", i), 32'(busy), (i == 3) ? 32'h0 : 32'h1);
        end
        tick();
        check("rot_done_drop", 32'(done), 32'h0);

        // SHIFT len=0: no change, immediate done
        mode = 2'b01; shift_len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("len0_par_out", 32'(par_out), 32'h8);
        check("len0_busy", 32'(busy), 32'h0);
        check("len0_done", 32'(done), 32'h1);
        tick();
        check("len0_done_drop", 32'(done), 32'h0);

        // SHIFT len=5 with ser_in=1; a LOAD start mid-burst is ignored
        mode = 2'b01; shift_len = 4'd5; ser_in = 1'b1; start = 1'b1;
        tick();
        mode = 2'b00; par_in = 4'b0000; shift_len = 4'd1;
        tick();
        start = 1'b0; mode = 2'b10;
        check("ign_par_out", 32'(par_out), 32'h1);
        check("ign_busy", 32'(busy), 32'h1);
        tick();
        tick();
        tick();
        check("len5_busy_last", 32'(busy), 32'h1);
        tick();
        check("len5_par_out", 32'(par_out), 32'hF);
        check("len5_done", 32'(done), 32'h1);
        check("len5_busy", 32'(busy), 32'h0);

        // Back-to-back: CLEAR issued in the done cycle is accepted
        mode = 2'b11; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_par_out", 32'(par_out), 32'h0);
        check("b2b_done", 32'(done), 32'h1);
        tick();
        check("b2b_done_drop", 32'(done), 32'h0);

        // Reset mid-burst abandons the burst with no done pulse
        mode = 2'b00; par_in = 4'b0110; start = 1'b1;
        tick();
        check("load3_par_out", 32'(par_out), 32'h6);
        mode = 2'b01; shift_len = 4'd6; ser_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("mid_par_out", 32'(par_out), 32'hD);
        rst = 1'b0;
        tick();
        check("midrst_par_out", 32'(par_out), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("post_rst%0d_done", i), 32'(done), 32'h0);
        end
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_par_out", 32'(par_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
